// File: rtl/add_share_ctrl_if.sv
// Request/grant/result bundle between the two adder clients (master) and add_share_ctrl (slave).
interface add_share_ctrl_if;
  logic        req0;
  logic        req1;
  logic [31:0] a0;
  logic [31:0] b0;
  logic [31:0] a1;
  logic [31:0] b1;
  logic        ci0;
  logic        ci1;
  logic        sub0;
  logic        sub1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] result;
  logic        co;

  modport master (
    output req0, req1, a0, b0, a1, b1, ci0, ci1, sub0, sub1,
    input  gnt0, gnt1, done0, done1, result, co
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, ci0, ci1, sub0, sub1,
    output gnt0, gnt1, done0, done1, result, co
  );
endinterface

// File: rtl/add_share_ctrl.sv
// Round-robin controller time-sharing one 32-bit carry-lookahead adder between two requesters.
// Optional feature: define ADDSHARE_SUB_EN to honour the sub0/sub1 subtract requests.
module cla32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ci_i,
  output logic [31:0] sum_o,
  output logic        co_o
);
  // 4-bit lookahead groups, with the group carry formed from group generate/propagate.
  always_comb begin : claLogic
    logic [32:0] c;
    logic [31:0] g;
    logic [31:0] p;
    logic        grpG;
    logic        grpP;
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c    = '0;
    c[0] = ci_i;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      grpG     = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grpP     = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      c[4*k+4] = grpG | (grpP & c[4*k]);
    end
    sum_o = p ^ c[31:0];
    co_o  = c[32];
  end
endmodule

module add_share_ctrl (
  input logic             clk,
  input logic             reset_n,
  add_share_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q;
  logic        lastGnt_q;
  logic [31:0] opA_q;
  logic [31:0] opB_q;
  logic        opCi_q;
  logic        gnt0_q;
  logic        gnt1_q;
  logic        done0_q;
  logic        done1_q;
  logic [31:0] result_q;
  logic        co_q;

  logic        pick1_d;
  logic        anyReq_d;
  logic        subSel_d;
  logic [31:0] opA_d;
  logic [31:0] opB_d;
  logic        opCi_d;
  logic [31:0] sum;
  logic        carry;

  // lastGnt_q doubles as the owner of the operation in flight.
  assign anyReq_d = bus.req0 | bus.req1;
  assign pick1_d  = bus.req1 & (~bus.req0 | ~lastGnt_q);

`ifdef ADDSHARE_SUB_EN
  assign subSel_d = pick1_d ? bus.sub1 : bus.sub0;
`else
  logic unusedSub;
  assign unusedSub = bus.sub0 ^ bus.sub1;
  assign subSel_d  = 1'b0;
`endif

  // Subtraction is folded in at capture time: a - b = a + ~b + 1.
  always_comb begin
    opA_d  = pick1_d ? bus.a1 : bus.a0;
    opB_d  = pick1_d ? bus.b1 : bus.b0;
    opCi_d = pick1_d ? bus.ci1 : bus.ci0;
    if (subSel_d) begin
      opB_d  = ~opB_d;
      opCi_d = 1'b1;
    end
  end

  cla32 u_cla (
    .a_i  (opA_q),
    .b_i  (opB_q),
    .ci_i (opCi_q),
    .sum_o(sum),
    .co_o (carry)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lastGnt_q <= 1'b1;
      opA_q     <= '0;
      opB_q     <= '0;
      opCi_q    <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result_q  <= '0;
      co_q      <= 1'b0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (anyReq_d) begin
            opA_q     <= opA_d;
            opB_q     <= opB_d;
            opCi_q    <= opCi_d;
            lastGnt_q <= pick1_d;
            gnt0_q    <= ~pick1_d;
            gnt1_q    <= pick1_d;
            state_q   <= CALC;
          end
        end
        CALC: begin
          result_q <= sum;
          co_q     <= carry;
          done0_q  <= ~lastGnt_q;
          done1_q  <= lastGnt_q;
          state_q  <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.co     = co_q;
endmodule

// File: tb/tb_add_share_ctrl.sv
// Bench for add_share_ctrl: directed scenarios plus random two-port traffic, checked every cycle
// against a transaction-level model (arbitration by rule, sums by plain 33-bit arithmetic).
module tb_add_share_ctrl;
`ifdef ADDSHARE_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  add_share_ctrl_if bus ();

  add_share_ctrl dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model state: cycle index, first cycle the shared adder is free again, pending completion.
  int          cyc = 0;
  int          freeAt = 0;
  int          doneAt = -1;
  int          pendPort = 0;
  int          lastWin = 1;
  logic [32:0] pendSum = '0;
  logic        expG0, expG1, expD0, expD1, expCo;
  logic [31:0] expRes;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at cycle %0d", tag, observed, expected, cyc);
    end
  endtask

  function automatic logic [32:0] refSum(input logic [31:0] a, input logic [31:0] b,
                                         input logic ci, input logic sub);
    if (SubEn && sub) return {1'b0, a} + {1'b0, ~b} + 33'd1;
    return {1'b0, a} + {1'b0, b} + {32'd0, ci};
  endfunction

  task automatic checkAllOutputs(input string pfx);
    checkOutput({pfx, "_gnt0"},   {31'd0, bus.gnt0},  {31'd0, expG0});
    checkOutput({pfx, "_gnt1"},   {31'd0, bus.gnt1},  {31'd0, expG1});
    checkOutput({pfx, "_done0"},  {31'd0, bus.done0}, {31'd0, expD0});
    checkOutput({pfx, "_done1"},  {31'd0, bus.done1}, {31'd0, expD1});
    checkOutput({pfx, "_result"}, bus.result,         expRes);
    checkOutput({pfx, "_co"},     {31'd0, bus.co},    {31'd0, expCo});
  endtask

  // One clock: snapshot inputs, advance the model on the edge, compare everything 1ns later.
  task automatic stepCycle();
    logic        r0, r1, c0, c1, s0, s1;
    logic [31:0] xa0, xb0, xa1, xb1;
    int          win;
    r0 = bus.req0; r1 = bus.req1;
    xa0 = bus.a0; xb0 = bus.b0; c0 = bus.ci0; s0 = bus.sub0;
    xa1 = bus.a1; xb1 = bus.b1; c1 = bus.ci1; s1 = bus.sub1;
    @(posedge clk);
    #1;
    cyc++;
    expG0 = 1'b0; expG1 = 1'b0; expD0 = 1'b0; expD1 = 1'b0;
    if (cyc == doneAt) begin
      if (pendPort == 0) expD0 = 1'b1;
      else expD1 = 1'b1;
      expRes = pendSum[31:0];
      expCo  = pendSum[32];
    end
    if (cyc >= freeAt && (r0 || r1)) begin
      if (r0 && r1) win = 1 - lastWin;
      else win = r1 ? 1 : 0;
      lastWin  = win;
      pendPort = win;
      pendSum  = (win == 1) ? refSum(xa1, xb1, c1, s1) : refSum(xa0, xb0, c0, s0);
      doneAt   = cyc + 1;
      freeAt   = cyc + 3;
      if (win == 1) expG1 = 1'b1;
      else expG0 = 1'b1;
    end
    checkAllOutputs("cyc");
  endtask

  // Requester behaviour: drop req in the gnt cycle, scramble operands whenever not requesting.
  task automatic applyStimulus(input int raisePct);
    if (bus.gnt0 || !bus.req0) begin
      bus.req0 = 1'b0;
      bus.a0 = $urandom; bus.b0 = $urandom;
      bus.ci0 = 1'($urandom_range(1, 0)); bus.sub0 = 1'($urandom_range(1, 0));
      if (!bus.gnt0 && int'($urandom_range(99, 0)) < raisePct) bus.req0 = 1'b1;
    end
    if (bus.gnt1 || !bus.req1) begin
      bus.req1 = 1'b0;
      bus.a1 = $urandom; bus.b1 = $urandom;
      bus.ci1 = 1'($urandom_range(1, 0)); bus.sub1 = 1'($urandom_range(1, 0));
      if (!bus.gnt1 && int'($urandom_range(99, 0)) < raisePct) bus.req1 = 1'b1;
    end
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #2;
    expG0 = 1'b0; expG1 = 1'b0; expD0 = 1'b0; expD1 = 1'b0; expRes = '0; expCo = 1'b0;
    checkAllOutputs("rst");
    repeat (2) @(posedge clk);
    #1;
    checkAllOutputs("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    freeAt  = 0;
    doneAt  = -1;
    lastWin = 1;
  endtask

  task automatic runCycles(input int n, input int raisePct);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      applyStimulus(raisePct);
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.ci0 = 1'b0; bus.ci1 = 1'b0; bus.sub0 = 1'b0; bus.sub1 = 1'b0;
    #1;
    doReset();
    runCycles(10, 0);

    $display("[TB] single add on port 0");
    bus.a0 = 32'hFFFF_FFFF; bus.b0 = 32'h0000_0001; bus.ci0 = 1'b0; bus.sub0 = 1'b0; bus.req0 = 1'b1;
    runCycles(5, 0);

    $display("[TB] simultaneous requests after reset");
    doReset();
    bus.a0 = 32'd5; bus.b0 = 32'd7; bus.ci0 = 1'b1; bus.sub0 = 1'b0; bus.req0 = 1'b1;
    bus.a1 = 32'h8000_0000; bus.b1 = 32'h8000_0000; bus.ci1 = 1'b0; bus.sub1 = 1'b0; bus.req1 = 1'b1;
    runCycles(8, 0);

    $display("[TB] continuous dual requests");
    runCycles(12, 100);

    $display("[TB] random traffic");
    runCycles(300, 40);
    runCycles(8, 0);

    $display("[TB] subtract request on port 1");
    bus.a1 = 32'd3; bus.b1 = 32'd5; bus.ci1 = 1'b0; bus.sub1 = 1'b1; bus.req1 = 1'b1;
    runCycles(5, 0);

    $display("[TB] reset during CALC");
    bus.a0 = 32'h1234_5678; bus.b0 = 32'h1111_1111; bus.ci0 = 1'b0; bus.sub0 = 1'b0; bus.req0 = 1'b1;
    runCycles(1, 0);
    doReset();
    bus.a0 = 32'h0000_00FF; bus.b0 = 32'h0000_0001; bus.ci0 = 1'b1; bus.sub0 = 1'b0; bus.req0 = 1'b1;
    runCycles(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
